// File: rtl/antares_shift_pkg.sv
// antares_shift_pkg
//   Shared definitions for the antares shift arbiter slice: FSM state
//   encoding, requester port IDs and the operand bundle layout that is
//   registered on accept and fed to the shifter.
package antares_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } shift_state_e;

    localparam logic SHIFT_PORT_ALU = 1'b0;
    localparam logic SHIFT_PORT_LSU = 1'b1;

    // data (32) + shamnt (5) + direction (1) + sign_extend (1)
    localparam int OPERAND_W = 39;

    typedef struct packed {
        logic        sign_extend;
        logic        direction;
        logic [4:0]  shamnt;
        logic [31:0] data;
    } operand_t;

endpackage

// File: rtl/antares_shifter.sv
// antares_shifter
//   Purely combinational 32-bit barrel shifter.
//   Ports:
//     operand : registered operand bundle (data, shamnt, direction, sign_extend)
//     result  : shifted value; left shifts zero-fill, right shifts fill with
//               data[31] only when sign_extend=1.
module antares_shifter
    import antares_shift_pkg::*;
(
    input  operand_t    operand,
    output logic [31:0] result
);

    logic [31:0] left_res;
    logic [31:0] right_res;

    assign left_res  = operand.data << operand.shamnt;
    // Arithmetic shift of the signed view gives the sign fill; the logical
    // shift covers the zero-fill case.
    assign right_res = operand.sign_extend
                     ? 32'($signed(operand.data) >>> operand.shamnt)
                     : (operand.data >> operand.shamnt);
    assign result    = operand.direction ? left_res : right_res;

endmodule

// File: rtl/antares_shift_arbiter.sv
// antares_shift_arbiter
//   Shares one antares_shifter between port 0 (execute-stage ALU) and
//   port 1 (load/store alignment). One operation in flight: accept ->
//   EXEC (shift evaluates from the operand register) -> DONE (result held
//   on the owner's response channel until consumed). A new request may be
//   accepted in the same cycle the owner consumes its result.
//   Ports (N = 0,1):
//     clk, rst_n           : clock, synchronous active-low reset
//     pN_req_valid/ready   : request handshake (ready is combinational on
//                            pN_resp_ready of the current owner)
//     pN_req_data/shamnt/direction/sign_extend : request operands
//     pN_resp_valid/ready  : response handshake
//     pN_resp_result       : per-port result register
//   Configuration macro: ANTARES_SHIFT_ROUND_ROBIN_EN -- round-robin tie
//   break using a last-grant register; otherwise fixed priority to port 0.
module antares_shift_arbiter
    import antares_shift_pkg::*;
#(
    parameter logic [31:0] RESULT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [31:0] p0_req_data,
    input  logic [4:0]  p0_req_shamnt,
    input  logic        p0_req_direction,
    input  logic        p0_req_sign_extend,
    output logic        p0_resp_valid,
    input  logic        p0_resp_ready,
    output logic [31:0] p0_resp_result,
    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [31:0] p1_req_data,
    input  logic [4:0]  p1_req_shamnt,
    input  logic        p1_req_direction,
    input  logic        p1_req_sign_extend,
    output logic        p1_resp_valid,
    input  logic        p1_resp_ready,
    output logic [31:0] p1_resp_result
);

    shift_state_e           state, state_nxt;
    logic [1:0]             req_valid;
    logic [1:0]             resp_ready;
    logic                   grant;
    logic                   window;
    logic                   accept;
    operand_t               op_sel;
    logic [OPERAND_W-1:0]   op_q;
    logic                   owner_q;
    logic [1:0][31:0]       result_q;
    logic [31:0]            shift_out;

    assign req_valid  = {p1_req_valid, p0_req_valid};
    assign resp_ready = {p1_resp_ready, p0_resp_ready};

`ifdef ANTARES_SHIFT_ROUND_ROBIN_EN
    logic last_grant_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Port 1 counts as last granted so port 0 wins the first tie.
            last_grant_q <= SHIFT_PORT_LSU;
        end else if (accept) begin
            last_grant_q <= grant;
        end
    end
`endif

    // Grant selection: a lone requester wins; ties go by configuration.
    always_comb begin
        grant = SHIFT_PORT_ALU;
        if (req_valid == 2'b11) begin
`ifdef ANTARES_SHIFT_ROUND_ROBIN_EN
            grant = (last_grant_q == SHIFT_PORT_ALU) ? SHIFT_PORT_LSU : SHIFT_PORT_ALU;
`else
            grant = SHIFT_PORT_ALU;
`endif
        end else if (req_valid[1]) begin
            grant = SHIFT_PORT_LSU;
        end
    end

    // Accept is possible when idle, or when the owner drains its result
    // this very cycle; reset blocks it outright.
    assign window = (state == ST_IDLE) || ((state == ST_DONE) && resp_ready[owner_q]);
    assign accept = rst_n && window && req_valid[grant];

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        // NOTE: default assignment first keeps every path assigned, so no
        // latch is inferred for state_nxt.
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: if (resp_ready[owner_q]) state_nxt = accept ? ST_EXEC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        p0_req_ready  = accept && (grant == SHIFT_PORT_ALU);
        p1_req_ready  = accept && (grant == SHIFT_PORT_LSU);
        // Gated by rst_n so an operation caught by reset never shows a response.
        p0_resp_valid = rst_n && (state == ST_DONE) && (owner_q == SHIFT_PORT_ALU);
        p1_resp_valid = rst_n && (state == ST_DONE) && (owner_q == SHIFT_PORT_LSU);
    end

    always_comb begin
        if (grant == SHIFT_PORT_LSU) begin
            op_sel = '{sign_extend: p1_req_sign_extend, direction: p1_req_direction,
                       shamnt: p1_req_shamnt, data: p1_req_data};
        end else begin
            op_sel = '{sign_extend: p0_req_sign_extend, direction: p0_req_direction,
                       shamnt: p0_req_shamnt, data: p0_req_data};
        end
    end

    // Operand register
    always_ff @(posedge clk) begin
        // NOTE: the operand/owner register has no reset: it is only consumed
        // in EXEC/DONE, which are reachable solely through an accept that loads it.
        if (accept) begin
            op_q    <= op_sel;
            owner_q <= grant;
        end
    end

    antares_shifter u_shifter (
        .operand (operand_t'(op_q)),
        .result  (shift_out)
    );

    // Result registers: loaded at the end of EXEC, otherwise held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= {2{RESULT_RESET}};
        end else if (state == ST_EXEC) begin
            result_q[owner_q] <= shift_out;
        end
    end

    assign p0_resp_result = result_q[0];
    assign p1_resp_result = result_q[1];

endmodule

// File: tb/tb_antares_shift_arbiter.sv
// tb_antares_shift_arbiter
//   Self-checking bench for antares_shift_arbiter: a cycle-level reference
//   model predicts req_ready, resp_valid and result registers; expected
//   results are queued per port at accept and a separate monitor compares
//   them on each response handshake.
module tb_antares_shift_arbiter;

    localparam logic [31:0] RST_VAL = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]       v, se, dir, rr;
    logic [1:0][31:0] d;
    logic [1:0][4:0]  sh;

    logic p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid;
    logic [31:0] p0_resp_result, p1_resp_result;
    wire [1:0]       rdy = {p1_req_ready, p0_req_ready};
    wire [1:0]       rv  = {p1_resp_valid, p0_resp_valid};
    wire [1:0][31:0] res = {p1_resp_result, p0_resp_result};

    always #5 clk = ~clk;

    antares_shift_arbiter #(.RESULT_RESET(RST_VAL)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .p0_req_valid       (v[0]),
        .p0_req_ready       (p0_req_ready),
        .p0_req_data        (d[0]),
        .p0_req_shamnt      (sh[0]),
        .p0_req_direction   (dir[0]),
        .p0_req_sign_extend (se[0]),
        .p0_resp_valid      (p0_resp_valid),
        .p0_resp_ready      (rr[0]),
        .p0_resp_result     (p0_resp_result),
        .p1_req_valid       (v[1]),
        .p1_req_ready       (p1_req_ready),
        .p1_req_data        (d[1]),
        .p1_req_shamnt      (sh[1]),
        .p1_req_direction   (dir[1]),
        .p1_req_sign_extend (se[1]),
        .p1_resp_valid      (p1_resp_valid),
        .p1_resp_ready      (rr[1]),
        .p1_resp_result     (p1_resp_result)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference shift, bit by bit from the shifting rules.
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int s,
                                              input bit left, input bit sx);
        logic [31:0] r;
        bit fill;
        fill = !left && sx && x[31];
        for (int i = 0; i < 32; i++) begin
            if (left) r[i] = (i >= s) ? x[i - s] : 1'b0;
            else      r[i] = (i + s <= 31) ? x[i + s] : fill;
        end
        return r;
    endfunction

    // Reference model state (cycle-level, transaction view)
    logic [31:0] sbq [2][$];
    bit          known = 0;
    bit          busy = 0;
    int          owner = 0;
    int          acc_c = 0;
    int          cyc = 0;
    int          last_g = 1;
    logic [31:0] exp_val;
    logic [31:0] last_res [2];
    bit          obs_acc;
    int          obs_g;

    task automatic step();
        logic [1:0] exp_rdy, exp_rv;
        bit win;
        int g;
        @(negedge clk);
        #1;
        exp_rdy = '0;
        exp_rv  = '0;
        g = 0;
        win = !busy || (cyc >= acc_c + 2 && rr[owner]);
        if (rst_n && known && win && v != 2'b00) begin
            if (v == 2'b11) begin
`ifdef ANTARES_SHIFT_ROUND_ROBIN_EN
                g = (last_g == 0) ? 1 : 0;
`else
                g = 0;
`endif
            end else begin
                g = v[1] ? 1 : 0;
            end
            exp_rdy[g] = 1'b1;
        end
        if (rst_n && busy && cyc >= acc_c + 2) exp_rv[owner] = 1'b1;

        for (int n = 0; n < 2; n++) begin
            check(rdy[n] === exp_rdy[n], n ? "p1_req_ready" : "p0_req_ready",
                  32'(rdy[n]), 32'(exp_rdy[n]));
            if (known) begin
                check(rv[n] === exp_rv[n], n ? "p1_resp_valid" : "p0_resp_valid",
                      32'(rv[n]), 32'(exp_rv[n]));
                check(res[n] === last_res[n], n ? "p1_resp_result" : "p0_resp_result",
                      res[n], last_res[n]);
            end
        end
        obs_acc = |(rdy & v);
        obs_g   = rdy[1] ? 1 : 0;

        // Advance the model across the coming edge.
        if (!rst_n) begin
            known = 1;
            busy  = 0;
            last_g = 1;
            last_res[0] = RST_VAL;
            last_res[1] = RST_VAL;
            sbq[0].delete();
            sbq[1].delete();
        end else if (known) begin
            if (busy && cyc == acc_c + 1) last_res[owner] = exp_val;
            if (busy && cyc >= acc_c + 2 && rr[owner]) busy = 0;
            if (exp_rdy != 2'b00) begin
                busy    = 1;
                owner   = g;
                acc_c   = cyc;
                last_g  = g;
                exp_val = ref_shift(d[g], int'(sh[g]), dir[g], se[g]);
                sbq[g].push_back(exp_val);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each consumed response with the queued expectation.
    always begin
        @(negedge clk);
        #2;
        for (int n = 0; n < 2; n++) begin
            if (rst_n && rv[n] && rr[n]) begin
                if (sbq[n].size() == 0) begin
                    check(1'b0, n ? "p1_unexpected_resp" : "p0_unexpected_resp", res[n], 32'h0);
                end else begin
                    logic [31:0] e;
                    e = sbq[n].pop_front();
                    check(res[n] === e, n ? "p1_sb_result" : "p0_sb_result", res[n], e);
                end
            end
        end
    end

    task automatic set_req(input int n, input bit val, input logic [31:0] data,
                           input logic [4:0] s, input bit left, input bit sx);
        v[n] = val; d[n] = data; sh[n] = s; dir[n] = left; se[n] = sx;
    endtask

    int grants[$];
    logic [31:0] exp_g;

    initial begin
        rst_n = 1'b0;
        v = '0; d = '0; sh = '0; dir = '0; se = '0; rr = 2'b11;

        // Reset with port 0 requesting; accepted on the first released edge.
        set_req(0, 1, 32'h0000_0001, 5'd4, 1, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        check(obs_acc && obs_g == 0, "first_accept_p0", 32'(obs_acc), 32'h1);
        v[0] = 1'b0;
        step(); step(); step();

        // Port 1 right shifts of 0x8000_0000 by 31.
        set_req(1, 1, 32'h8000_0000, 5'd31, 0, 1);
        step(); v[1] = 1'b0; step(); step(); step();
        set_req(1, 1, 32'h8000_0000, 5'd31, 0, 0);
        step(); v[1] = 1'b0; step(); step(); step();

        // Contention, both response channels ready.
        set_req(0, 1, 32'h1234_5678, 5'd3, 1, 0);
        set_req(1, 1, 32'hF000_000F, 5'd2, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_acc) grants.push_back(obs_g);
        end
        check(grants.size() >= 4, "contention_accepts", 32'(grants.size()), 32'd4);
`ifdef ANTARES_SHIFT_ROUND_ROBIN_EN
        exp_g = 32'b1010;
`else
        exp_g = 32'b0000;
`endif
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check(grants[i] == int'(exp_g[i]), "contention_grant", 32'(grants[i]), 32'(exp_g[i]));
        v = 2'b00;
        step(); step(); step();

        // Backpressure on port 0 with port 1 waiting.
        set_req(0, 1, 32'hA5A5_0000, 5'd8, 0, 1);
        step();
        v[0] = 1'b0; rr[0] = 1'b0;
        set_req(1, 1, 32'h0000_00FF, 5'd24, 1, 0);
        for (int i = 0; i < 6; i++) step();
        rr[0] = 1'b1;
        step();
        check(obs_acc && obs_g == 1, "bp_release_p1_accept", 32'(obs_g), 32'h1);
        v[1] = 1'b0;
        step(); step(); step();

        // Reset while in EXEC: operation discarded, no response.
        set_req(0, 1, 32'hDEAD_BEEF, 5'd1, 1, 0);
        step();
        v[0] = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step(); step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++) begin
                set_req(n, $urandom_range(0, 1),
                        ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom,
                        ($urandom_range(0, 7) == 0) ? 5'(31 * $urandom_range(0, 1)) : 5'($urandom),
                        $urandom_range(0, 1), $urandom_range(0, 1));
                rr[n] = ($urandom_range(0, 3) != 0);
            end
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end

        // Drain and confirm every queued response was delivered.
        rst_n = 1'b1; v = 2'b00; rr = 2'b11;
        for (int i = 0; i < 4; i++) step();
        check(sbq[0].size() == 0, "p0_queue_drained", 32'(sbq[0].size()), 32'h0);
        check(sbq[1].size() == 0, "p1_queue_drained", 32'(sbq[1].size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
